// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues imem requests for the current PC,
// delivers fetched words to IF/ID, drives the PC register enable/next value,
// and absorbs downstream stalls and branch redirects.
module if_fetch_ctrl #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_pc_en,
   output logic [ADDR_W-1:0] o_pc_next,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic              i_imem_ack,
   input  logic [31:0]       i_imem_rdata,
   output logic              o_inst_valid,
   output logic [31:0]       o_inst,
   output logic [ADDR_W-1:0] o_inst_pc
);

   localparam int unsigned INST_W = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [INST_W-1:0]   hold_q, hold_d;
   logic                squash_q, squash_d;
   logic                deliver;
   logic                fetch_entry;

   // Redirect targets are word aligned; the two low bits are intentionally dropped.
   logic                unused_redirect_lo;
   assign unused_redirect_lo = ^i_redirect_pc[1:0];

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         hold_q   <= '0;
         squash_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         hold_q   <= hold_d;
         squash_q <= squash_d;
      end
   end

   // Next-state, delivery and PC-update logic.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      hold_d      = hold_q;
      squash_d    = squash_q;
      deliver     = 1'b0;
      fetch_entry = 1'b0;

      case (state_q)
         S_IDLE: begin
            fetch_entry = 1'b1;
         end
         S_FETCH: begin
            if (!i_imem_ack) begin
               // Request cannot be withdrawn; remember to drop its data.
               if (i_redirect) squash_d = 1'b1;
            end else if (squash_q || i_redirect) begin
               fetch_entry = 1'b1;
            end else if (!i_stall) begin
               deliver     = 1'b1;
               fetch_entry = 1'b1;
            end else begin
               hold_d  = i_imem_rdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (i_redirect) begin
               fetch_entry = 1'b1;
            end else if (!i_stall) begin
               deliver     = 1'b1;
               fetch_entry = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      o_pc_en   = deliver | i_redirect;
      o_pc_next = i_redirect ? {i_redirect_pc[ADDR_W-1:2], 2'b00}
                             : i_pc + ADDR_W'(4);

      // Latch the PC being written this edge so the new request does not lag the PC register.
      if (fetch_entry) begin
         state_d  = S_FETCH;
         addr_d   = o_pc_en ? o_pc_next : i_pc;
         squash_d = 1'b0;
      end

      o_inst_valid = deliver;
      o_inst       = (state_q == S_FETCH) ? i_imem_rdata : hold_q;
   end

   assign o_imem_req  = (state_q == S_FETCH);
   assign o_imem_addr = addr_q;
   assign o_inst_pc   = addr_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a PC register and a variable-latency memory model.
module tb_if_fetch_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_pc;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_pc_en;
   logic [31:0] o_pc_next;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;

   int checks   = 0;
   int failures = 0;

   logic [31:0] waits;
   logic [31:0] wcnt;
   logic        ovr_en;
   logic [31:0] ovr_addr;
   logic [31:0] ovr_data;

   if_fetch_ctrl #(.ADDR_W(32)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_pc          (i_pc),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_pc_en       (o_pc_en),
      .o_pc_next     (o_pc_next),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (i_imem_ack),
      .i_imem_rdata  (i_imem_rdata),
      .o_inst_valid  (o_inst_valid),
      .o_inst        (o_inst),
      .o_inst_pc     (o_inst_pc)
   );

   always #5 i_clk = ~i_clk;

   // PC register downstream of the controller.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     i_pc <= 32'h0;
      else if (o_pc_en) i_pc <= o_pc_next;
   end

   // Memory: ack after 'waits' idle request cycles.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                      wcnt <= 32'h0;
      else if (!o_imem_req || i_imem_ack) wcnt <= 32'h0;
      else                               wcnt <= wcnt + 32'h1;
   end
   assign i_imem_ack   = o_imem_req && (wcnt == waits);
   assign i_imem_rdata = (ovr_en && o_imem_addr == ovr_addr) ? ovr_data
                                                              : (o_imem_addr ^ 32'hA5A5A5A5);

   task automatic do_reset(input logic [31:0] w);
      i_rst_n = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
      ovr_en = 1'b0; ovr_addr = 32'h0; ovr_data = 32'h0; waits = w;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset(32'd0);
      i_rst_n = 1'b0;
      #1;
      checks++; if (o_imem_req !== 1'b0)   begin failures++; $display("FAIL rst_req got=%0h exp=0", o_imem_req); end
      checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", o_inst_valid); end
      checks++; if (o_pc_en !== 1'b0)      begin failures++; $display("FAIL rst_pc_en got=%0h exp=0", o_pc_en); end
      checks++; if (o_imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", o_imem_addr); end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      checks++; if (o_imem_req !== 1'b0)   begin failures++; $display("FAIL idle_req got=%0h exp=0", o_imem_req); end
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk); #1;
         checks++; if (o_inst_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%0h exp=1", i, o_inst_valid); end
         checks++; if (o_inst_pc !== 32'(4*i)) begin failures++; $display("FAIL seq_pc[%0d] got=%0h exp=%0h", i, o_inst_pc, 32'(4*i)); end
         checks++; if (o_inst !== (32'(4*i) ^ 32'hA5A5A5A5)) begin failures++; $display("FAIL seq_inst[%0d] got=%0h exp=%0h", i, o_inst, 32'(4*i) ^ 32'hA5A5A5A5); end
         checks++; if (o_pc_en !== 1'b1) begin failures++; $display("FAIL seq_pc_en[%0d] got=%0h exp=1", i, o_pc_en); end
      end
   endtask

   task automatic test_wait2();
      do_reset(32'd2);
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge i_clk); #1;
            checks++; if (o_imem_req !== 1'b1) begin failures++; $display("FAIL w2_req[%0d.%0d] got=%0h exp=1", k, c, o_imem_req); end
            checks++; if (o_imem_addr !== 32'(4*k)) begin failures++; $display("FAIL w2_addr[%0d.%0d] got=%0h exp=%0h", k, c, o_imem_addr, 32'(4*k)); end
            checks++; if (o_inst_valid !== (c == 2)) begin failures++; $display("FAIL w2_valid[%0d.%0d] got=%0h exp=%0h", k, c, o_inst_valid, (c == 2)); end
         end
      end
   endtask

   task automatic test_hold();
      do_reset(32'd0);
      ovr_en = 1'b1; ovr_addr = 32'h8; ovr_data = 32'h00A00093;
      repeat (2) @(negedge i_clk);
      @(negedge i_clk); i_stall = 1'b1; #1;
      checks++; if (o_imem_addr !== 32'h8) begin failures++; $display("FAIL hold_ack_addr got=%0h exp=8", o_imem_addr); end
      checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL hold_ack_valid got=%0h exp=0", o_inst_valid); end
      checks++; if (o_pc_en !== 1'b0)      begin failures++; $display("FAIL hold_ack_pc_en got=%0h exp=0", o_pc_en); end
      for (int i = 0; i < 2; i++) begin
         @(negedge i_clk); #1;
         checks++; if (o_imem_req !== 1'b0)   begin failures++; $display("FAIL hold_req[%0d] got=%0h exp=0", i, o_imem_req); end
         checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL hold_valid[%0d] got=%0h exp=0", i, o_inst_valid); end
      end
      @(negedge i_clk); i_stall = 1'b0; #1;
      checks++; if (o_inst_valid !== 1'b1)       begin failures++; $display("FAIL rel_valid got=%0h exp=1", o_inst_valid); end
      checks++; if (o_inst !== 32'h00A00093)     begin failures++; $display("FAIL rel_inst got=%0h exp=00a00093", o_inst); end
      checks++; if (o_inst_pc !== 32'h8)         begin failures++; $display("FAIL rel_pc got=%0h exp=8", o_inst_pc); end
      checks++; if (o_pc_next !== 32'hC)         begin failures++; $display("FAIL rel_pc_next got=%0h exp=c", o_pc_next); end
      @(negedge i_clk); #1;
      checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hC) begin failures++; $display("FAIL rel_next req=%0h addr=%0h exp req=1 addr=c", o_imem_req, o_imem_addr); end
   endtask

   task automatic test_redirect_pending();
      do_reset(32'd2);
      repeat (12) @(negedge i_clk);
      @(negedge i_clk); i_redirect = 1'b1; i_redirect_pc = 32'h103; #1;
      checks++; if (o_imem_addr !== 32'h10) begin failures++; $display("FAIL rdp_addr got=%0h exp=10", o_imem_addr); end
      checks++; if (o_inst_valid !== 1'b0)  begin failures++; $display("FAIL rdp_valid got=%0h exp=0", o_inst_valid); end
      checks++; if (o_pc_en !== 1'b1)       begin failures++; $display("FAIL rdp_pc_en got=%0h exp=1", o_pc_en); end
      checks++; if (o_pc_next !== 32'h100)  begin failures++; $display("FAIL rdp_pc_next got=%0h exp=100", o_pc_next); end
      @(negedge i_clk); i_redirect = 1'b0; #1;
      checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h10) begin failures++; $display("FAIL rdp_held req=%0h addr=%0h exp req=1 addr=10", o_imem_req, o_imem_addr); end
      @(negedge i_clk); #1;
      checks++; if (o_imem_addr !== 32'h10)  begin failures++; $display("FAIL rdp_ack_addr got=%0h exp=10", o_imem_addr); end
      checks++; if (o_inst_valid !== 1'b0 || o_pc_en !== 1'b0) begin failures++; $display("FAIL rdp_squash valid=%0h pc_en=%0h exp 0 0", o_inst_valid, o_pc_en); end
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk); #1;
         checks++; if (o_imem_addr !== 32'h100) begin failures++; $display("FAIL rdp_tgt_addr[%0d] got=%0h exp=100", c, o_imem_addr); end
         checks++; if (o_inst_valid !== (c == 2)) begin failures++; $display("FAIL rdp_tgt_valid[%0d] got=%0h exp=%0h", c, o_inst_valid, (c == 2)); end
      end
      checks++; if (o_inst !== 32'hA5A5A4A5) begin failures++; $display("FAIL rdp_tgt_inst got=%0h exp=a5a5a4a5", o_inst); end
   endtask

   task automatic test_redirect_ack();
      do_reset(32'd0);
      @(negedge i_clk); #1;
      @(negedge i_clk); i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE; #1;
      checks++; if (o_imem_addr !== 32'h4)   begin failures++; $display("FAIL rda_addr got=%0h exp=4", o_imem_addr); end
      checks++; if (o_inst_valid !== 1'b0)   begin failures++; $display("FAIL rda_valid got=%0h exp=0", o_inst_valid); end
      checks++; if (o_pc_next !== 32'hFFFF_FFFC || o_pc_en !== 1'b1) begin failures++; $display("FAIL rda_pc_next got=%0h en=%0h exp=fffffffc en=1", o_pc_next, o_pc_en); end
      @(negedge i_clk); i_redirect = 1'b0; #1;
      checks++; if (o_imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rda_tgt_addr got=%0h exp=fffffffc", o_imem_addr); end
      checks++; if (o_inst_valid !== 1'b1 || o_inst !== 32'h5A5A_5A59) begin failures++; $display("FAIL rda_tgt_inst v=%0h got=%0h exp v=1 5a5a5a59", o_inst_valid, o_inst); end
      checks++; if (o_pc_next !== 32'h0)     begin failures++; $display("FAIL rda_wrap got=%0h exp=0", o_pc_next); end
      @(negedge i_clk); #1;
      checks++; if (o_imem_addr !== 32'h0 || o_inst_valid !== 1'b1) begin failures++; $display("FAIL rda_wrap_fetch addr=%0h v=%0h exp addr=0 v=1", o_imem_addr, o_inst_valid); end
   endtask

   task automatic test_redirect_hold();
      do_reset(32'd0);
      @(negedge i_clk); i_stall = 1'b1; #1;
      checks++; if (o_inst_valid !== 1'b0) begin failures++; $display("FAIL rdh_stall_valid got=%0h exp=0", o_inst_valid); end
      @(negedge i_clk); i_stall = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h200; #1;
      checks++; if (o_imem_req !== 1'b0 || o_inst_valid !== 1'b0) begin failures++; $display("FAIL rdh_hold req=%0h v=%0h exp 0 0", o_imem_req, o_inst_valid); end
      checks++; if (o_pc_en !== 1'b1 || o_pc_next !== 32'h200) begin failures++; $display("FAIL rdh_pc en=%0h next=%0h exp en=1 next=200", o_pc_en, o_pc_next); end
      @(negedge i_clk); i_redirect = 1'b0; #1;
      checks++; if (o_imem_addr !== 32'h200 || o_imem_req !== 1'b1) begin failures++; $display("FAIL rdh_tgt addr=%0h req=%0h exp addr=200 req=1", o_imem_addr, o_imem_req); end
      checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h200) begin failures++; $display("FAIL rdh_tgt_deliver v=%0h pc=%0h exp v=1 pc=200", o_inst_valid, o_inst_pc); end
   endtask

   task automatic test_async_reset();
      do_reset(32'd2);
      repeat (3) @(negedge i_clk);
      @(negedge i_clk); #1;
      checks++; if (o_imem_addr !== 32'h4 || o_imem_req !== 1'b1) begin failures++; $display("FAIL ar_pre addr=%0h req=%0h exp addr=4 req=1", o_imem_addr, o_imem_req); end
      @(negedge i_clk); #2;
      i_rst_n = 1'b0; #1;
      checks++; if (o_imem_req !== 1'b0 || o_inst_valid !== 1'b0) begin failures++; $display("FAIL ar_out req=%0h v=%0h exp 0 0", o_imem_req, o_inst_valid); end
      checks++; if (o_imem_addr !== 32'h0 || o_pc_en !== 1'b0) begin failures++; $display("FAIL ar_addr addr=%0h en=%0h exp 0 0", o_imem_addr, o_pc_en); end
      @(negedge i_clk); i_rst_n = 1'b1; #1;
      checks++; if (o_imem_req !== 1'b0) begin failures++; $display("FAIL ar_idle_req got=%0h exp=0", o_imem_req); end
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk); #1;
         checks++; if (o_imem_addr !== 32'h0 || o_inst_valid !== (c == 2)) begin failures++; $display("FAIL ar_restart[%0d] addr=%0h v=%0h exp addr=0 v=%0h", c, o_imem_addr, o_inst_valid, (c == 2)); end
      end
      checks++; if (o_inst !== 32'hA5A5A5A5) begin failures++; $display("FAIL ar_inst got=%0h exp=a5a5a5a5", o_inst); end
   endtask

   initial begin
      test_reset();
      test_wait2();
      test_hold();
      test_redirect_pending();
      test_redirect_ack();
      test_redirect_hold();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
